// File: rtl/block_dispatcher_pkg.sv
// Shared types for the kernel block dispatcher: top FSM states, per-core slot
// states and the block ID type.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package block_dispatcher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DONE
    } dispatch_state_t;

    typedef enum logic {
        FREE,
        RUN
    } core_slot_state_t;

    typedef logic [`DATA_WIDTH-1:0] block_id_t;

endpackage

// File: rtl/block_dispatcher_priority_encoder.sv
// Lowest-set-bit selector: one-hot grant of the lowest requesting bit plus a
// valid flag. Purely combinational.
module block_dispatcher_priority_encoder #(
    parameter int N = 1
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         valid
);

    // Two's-complement trick isolates the lowest set bit.
    assign grant = req & (~req + N'(1));
    assign valid = |req;

endmodule

// File: rtl/block_dispatcher.sv
// Kernel-level scheduler: latches num_blocks on launch, hands block IDs to the
// lowest free core, tracks completions and signals execution_done.
// Optional build macro DISPATCHER_CYCLE_COUNT_EN adds the kernel_cycles output.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module block_dispatcher
    import block_dispatcher_pkg::*;
#(
    parameter int NUM_CORES  = 1,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 execution_start,
    output logic                                 execution_done,
    input  logic [DATA_WIDTH-1:0]                num_blocks,
    output logic [NUM_CORES-1:0]                 core_reset,
    output logic [NUM_CORES-1:0]                 core_start,
    output logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_block_id,
    input  logic [NUM_CORES-1:0]                 core_done
`ifdef DISPATCHER_CYCLE_COUNT_EN
    ,
    output logic [31:0]                          kernel_cycles
`endif
);

    dispatch_state_t         state_reg;
    dispatch_state_t         state_next;
    logic [DATA_WIDTH-1:0]   num_blocks_reg;
    logic [DATA_WIDTH-1:0]   dispatched_reg;
    logic [DATA_WIDTH-1:0]   retired_reg;
    logic [DATA_WIDTH-1:0]   done_count;
    logic [NUM_CORES-1:0]    free_mask;
    logic [NUM_CORES-1:0]    grant;
    logic                    grant_valid;
    logic [NUM_CORES-1:0]    done_valid;
    logic                    launch;
    logic                    in_dispatch;
    logic                    dispatch_fire;

    assign launch        = (state_reg == IDLE) && execution_start;
    assign in_dispatch   = (state_reg == DISPATCH);
    assign dispatch_fire = in_dispatch && (dispatched_reg < num_blocks_reg) && grant_valid;
    assign execution_done = (state_reg == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (execution_start) state_next = DISPATCH;
            DISPATCH: if (retired_reg == num_blocks_reg) state_next = DONE;
            DONE:     if (!execution_start) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Free slots compete for the next block; freshly freed cores are still RUN
    // during this decision and therefore wait one cycle.
    block_dispatcher_priority_encoder #(
        .N(NUM_CORES)
    ) u_priority_encoder (
        .req   (free_mask),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        done_count = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            done_count = done_count + DATA_WIDTH'(done_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_blocks_reg <= '0;
            dispatched_reg <= '0;
            retired_reg    <= '0;
        end else if (launch) begin
            num_blocks_reg <= num_blocks;
            dispatched_reg <= '0;
            retired_reg    <= '0;
        end else begin
            if (dispatch_fire) begin
                dispatched_reg <= dispatched_reg + DATA_WIDTH'(1);
            end
            retired_reg <= retired_reg + done_count;
        end
    end

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        core_slot_state_t      slot_reg;
        logic [DATA_WIDTH-1:0] block_id_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                slot_reg     <= FREE;
                block_id_reg <= '0;
            end else if (dispatch_fire && grant[gi]) begin
                slot_reg     <= RUN;
                block_id_reg <= dispatched_reg;
            end else if (done_valid[gi]) begin
                slot_reg <= FREE;
            end
        end

        assign free_mask[gi]     = (slot_reg == FREE);
        assign done_valid[gi]    = in_dispatch && (slot_reg == RUN) && core_done[gi];
        assign core_reset[gi]    = (slot_reg == FREE);
        assign core_start[gi]    = (slot_reg == RUN);
        assign core_block_id[gi] = block_id_reg;
    end

`ifdef DISPATCHER_CYCLE_COUNT_EN
    logic [31:0] kernel_cycles_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            kernel_cycles_reg <= '0;
        end else if (launch) begin
            kernel_cycles_reg <= '0;
        end else if (in_dispatch && (kernel_cycles_reg != '1)) begin
            kernel_cycles_reg <= kernel_cycles_reg + 32'd1;
        end
    end

    assign kernel_cycles = kernel_cycles_reg;
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher with 4 cores; a small core responder
// pulses core_done a configurable number of cycles after each core starts.
module tb_block_dispatcher;

    localparam int NC = 4;
    localparam int DW = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  execution_start;
    logic                  execution_done;
    logic [DW-1:0]         num_blocks;
    logic [NC-1:0]         core_reset;
    logic [NC-1:0]         core_start;
    logic [NC-1:0][DW-1:0] core_block_id;
    logic [NC-1:0]         core_done;
`ifdef DISPATCHER_CYCLE_COUNT_EN
    logic [31:0]           kernel_cycles;
`endif

    block_dispatcher #(
        .NUM_CORES  (NC),
        .DATA_WIDTH (DW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .execution_start (execution_start),
        .execution_done  (execution_done),
        .num_blocks      (num_blocks),
        .core_reset      (core_reset),
        .core_start      (core_start),
        .core_block_id   (core_block_id),
        .core_done       (core_done)
`ifdef DISPATCHER_CYCLE_COUNT_EN
        ,
        .kernel_cycles   (kernel_cycles)
`endif
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            lat_cfg [NC];
    int            log_cyc [16];
    int            log_core[16];
    int            log_id  [16];
    int            n_log;
    int            done_cyc;
    int            done_drops;
    int            comp_viol;
    logic [NC-1:0] start_mask;
    longint        kc_at1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string t, input int idx, input int cyc, input int core, input int id);
        check_eq($sformatf("%s.log%0d.cycle", t, idx), log_cyc[idx], cyc);
        check_eq($sformatf("%s.log%0d.core", t, idx), log_core[idx], core);
        check_eq($sformatf("%s.log%0d.id", t, idx), log_id[idx], id);
    endtask

    // Launch in cycle 0 and observe for a fixed number of cycles while the
    // responder answers each started core after lat_cfg[core] cycles.
    task automatic run_kernel(input int nb, input int cycles, input bit hold_start);
        int age [NC];
        for (int k = 0; k < NC; k++) age[k] = 0;
        for (int i = 0; i < 16; i++) begin
            log_cyc[i] = -1; log_core[i] = -1; log_id[i] = -1;
        end
        n_log = 0; done_cyc = -1; done_drops = 0; comp_viol = 0;
        start_mask = '0; kc_at1 = -1;
        num_blocks = DW'(nb);
        execution_start = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            for (int k = 0; k < NC; k++) begin
                if (core_start[k]) begin
                    age[k]++;
                    if (age[k] == 1 && n_log < 16) begin
                        log_cyc[n_log]  = c;
                        log_core[n_log] = k;
                        log_id[n_log]   = int'(core_block_id[k]);
                        $display("dispatch: nb=%0d cycle %0d core %0d block %0d", nb, c, k, core_block_id[k]);
                        n_log++;
                    end
                end else begin
                    age[k] = 0;
                end
                core_done[k] = core_start[k] && (age[k] == lat_cfg[k] + 1);
            end
            start_mask |= core_start;
            if (core_reset !== ~core_start) comp_viol++;
            if (execution_done && done_cyc < 0) done_cyc = c;
            else if (!execution_done && done_cyc >= 0) done_drops++;
`ifdef DISPATCHER_CYCLE_COUNT_EN
            if (c == 1) kc_at1 = kernel_cycles;
`endif
            step();
            if (!hold_start) execution_start = 1'b0;
        end
        core_done = '0;
    endtask

    initial begin
        reset = 1'b1;
        execution_start = 1'b0;
        num_blocks = '0;
        core_done = '0;
        for (int k = 0; k < NC; k++) lat_cfg[k] = 1000;
        step();
        step();
        check_eq("rst.done", execution_done, 0);
        check_eq("rst.core_reset", core_reset, 4'hF);
        check_eq("rst.core_start", core_start, 0);
        check_eq("rst.block_id", core_block_id, 0);
        reset = 1'b0;

        // Empty kernel with start held high through DONE.
        run_kernel(0, 8, 1'b1);
        check_eq("t1.done_cycle", done_cyc, 2);
        check_eq("t1.start_mask", start_mask, 0);
        check_eq("t1.done_drops", done_drops, 0);
        check_eq("t1.reset_vs_start", comp_viol, 0);
        check_eq("t1.done_held", execution_done, 1);
`ifdef DISPATCHER_CYCLE_COUNT_EN
        check_eq("t1.kernel_cycles", kernel_cycles, 1);
`endif
        execution_start = 1'b0;
        step();
        check_eq("t1.back_to_idle", execution_done, 0);

        // Three blocks on four cores, nobody completes.
        for (int k = 0; k < NC; k++) lat_cfg[k] = 1000;
        run_kernel(3, 8, 1'b0);
        check_eq("t2.n_dispatch", n_log, 3);
        check_log("t2", 0, 2, 0, 0);
        check_log("t2", 1, 3, 1, 1);
        check_log("t2", 2, 4, 2, 2);
        check_eq("t2.start_mask", start_mask, 4'b0111);
        check_eq("t2.core3_reset", core_reset[3], 1);
        check_eq("t2.no_done", done_cyc, -1);
        check_eq("t2.reset_vs_start", comp_viol, 0);

        // Reset with three cores running.
        reset = 1'b1;
        step();
        check_eq("t5.core_start", core_start, 0);
        check_eq("t5.core_reset", core_reset, 4'hF);
        check_eq("t5.block_id", core_block_id, 0);
        check_eq("t5.done", execution_done, 0);
`ifdef DISPATCHER_CYCLE_COUNT_EN
        check_eq("t5.kernel_cycles", kernel_cycles, 0);
`endif
        reset = 1'b0;

        // Five blocks, each core answers 10 cycles after starting.
        for (int k = 0; k < NC; k++) lat_cfg[k] = 10;
        run_kernel(5, 32, 1'b0);
        check_eq("t3.n_dispatch", n_log, 5);
        check_log("t3", 0, 2, 0, 0);
        check_log("t3", 1, 3, 1, 1);
        check_log("t3", 2, 4, 2, 2);
        check_log("t3", 3, 5, 3, 3);
        check_log("t3", 4, 14, 0, 4);
        check_eq("t3.done_cycle", done_cyc, 26);
        check_eq("t3.reset_vs_start", comp_viol, 0);
`ifdef DISPATCHER_CYCLE_COUNT_EN
        check_eq("t3.kernel_cycles", kernel_cycles, 25);
`endif

        // Cores 0 and 1 finish together; blocks 4 and 5 follow one cycle apart.
        lat_cfg[0] = 5; lat_cfg[1] = 4; lat_cfg[2] = 20; lat_cfg[3] = 20;
        run_kernel(6, 32, 1'b0);
        check_eq("t4.n_dispatch", n_log, 6);
        check_log("t4", 0, 2, 0, 0);
        check_log("t4", 1, 3, 1, 1);
        check_log("t4", 2, 4, 2, 2);
        check_log("t4", 3, 5, 3, 3);
        check_log("t4", 4, 9, 0, 4);
        check_log("t4", 5, 10, 1, 5);
        check_eq("t4.done_cycle", done_cyc, 27);
        check_eq("t4.reset_vs_start", comp_viol, 0);
`ifdef DISPATCHER_CYCLE_COUNT_EN
        check_eq("t4.kc_cleared", kc_at1, 0);
        check_eq("t4.kernel_cycles", kernel_cycles, 26);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
